// File: rtl/enigma_rotor.sv
// rtl/enigma_rotor.sv - Enigma rotor: position register, ring offset, one-hot forward/backward paths.
// Optional build macro: ENIGMA_DOUBLE_STEP_EN (middle-rotor double-step on the notch).
module enigma_rotor #(
    parameter logic [8*26-1:0] WIRING    = "EKMFLGDQVZNTOWYHXUSPAIBRCJ",
    parameter logic [7:0]      NOTCH     = "Q",
    parameter int              RESET_POS = 0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        key,
    input  logic        step_in,
    output logic        step_out,
    input  logic        load,
    input  logic [4:0]  load_pos,
    input  logic [4:0]  ring,
    output logic [4:0]  pos,
    input  logic [25:0] f_in,
    output logic [25:0] f_out,
    input  logic [25:0] b_in,
    output logic [25:0] b_out
);

    localparam logic [4:0] NOTCH_POS = 5'(NOTCH - 8'd65);

    logic [4:0]  r_pos;
    logic [4:0]  w_ring_eff;
    logic [5:0]  w_off_raw;
    logic [4:0]  w_off;
    logic        w_at_notch;
    logic        w_advance;
    logic [25:0] w_f_rot;
    logic [25:0] w_f_map;
    logic [25:0] w_b_rot;
    logic [25:0] w_b_map;

    // Output contact (0..25) of the fixed wiring for input contact k.
    function automatic logic [4:0] wire_of(input int k);
        logic [7:0] ch;
        ch = WIRING[8*(25-k) +: 8];
        return 5'(ch - 8'd65);
    endfunction

    // y[c] = x[(c - sh) mod 26]
    function automatic logic [25:0] rot_up(input logic [25:0] x, input logic [4:0] sh);
        logic [51:0] d;
        d = {x, x};
        return d[6'd26 - {1'b0, sh} +: 26];
    endfunction

    // y[c] = x[(c + sh) mod 26]
    function automatic logic [25:0] rot_down(input logic [25:0] x, input logic [4:0] sh);
        logic [51:0] d;
        d = {x, x};
        return d[{1'b0, sh} +: 26];
    endfunction

    assign w_ring_eff = (ring > 5'd25) ? 5'd0 : ring;
    assign w_off_raw  = {1'b0, r_pos} + 6'd26 - {1'b0, w_ring_eff};
    assign w_off      = (w_off_raw >= 6'd26) ? 5'(w_off_raw - 6'd26) : w_off_raw[4:0];

    assign w_at_notch = (r_pos == NOTCH_POS);
    assign step_out   = key & w_at_notch;

`ifdef ENIGMA_DOUBLE_STEP_EN
    assign w_advance = step_in | (key & w_at_notch);
`else
    assign w_advance = step_in;
`endif

    // Rotate into the rotor frame, cross the fixed wiring, rotate back out.
    always_comb begin
        w_f_rot = rot_up(f_in, w_off);
        w_b_rot = rot_up(b_in, w_off);
        w_f_map = '0;
        w_b_map = '0;
        for (int c = 0; c < 26; c++) begin
            w_f_map[wire_of(c)] = w_f_rot[c];
            w_b_map[c]          = w_b_rot[wire_of(c)];
        end
    end

    assign f_out = rot_down(w_f_map, w_off);
    assign b_out = rot_down(w_b_map, w_off);
    assign pos   = r_pos;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pos <= 5'(RESET_POS);
        end else if (load) begin
            if (load_pos <= 5'd25) begin
                r_pos <= load_pos;
            end
        end else if (w_advance) begin
            r_pos <= (r_pos == 5'd25) ? 5'd0 : r_pos + 5'd1;
        end
    end

endmodule

// File: tb/tb_enigma_rotor.sv
// tb/tb_enigma_rotor.sv - directed self-checking bench for enigma_rotor at default wiring and notch.
module tb_enigma_rotor;

    logic        clk;
    logic        reset_n;
    logic        key;
    logic        step_in;
    logic        step_out;
    logic        load;
    logic [4:0]  load_pos;
    logic [4:0]  ring;
    logic [4:0]  pos;
    logic [25:0] f_in;
    logic [25:0] f_out;
    logic [25:0] b_in;
    logic [25:0] b_out;

    int checks;
    int failures;
    int wmap [26];

    enigma_rotor dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .key      (key),
        .step_in  (step_in),
        .step_out (step_out),
        .load     (load),
        .load_pos (load_pos),
        .ring     (ring),
        .pos      (pos),
        .f_in     (f_in),
        .f_out    (f_out),
        .b_in     (b_in),
        .b_out    (b_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [4:0] p);
        load     = 1'b1;
        load_pos = p;
        tick();
        load     = 1'b0;
    endtask

    task automatic build_model();
        logic [8*26-1:0] ws;
        logic [7:0]      ch;
        ws = "EKMFLGDQVZNTOWYHXUSPAIBRCJ";
        for (int k = 0; k < 26; k++) begin
            ch = ws[8*(25-k) +: 8];
            wmap[k] = int'(ch) - 65;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        key = 1'b1;
        #3;
        checks++;
        if (pos !== 5'd0) begin
            failures++;
            $display("FAIL reset_pos: got %0d want 0", pos);
        end
        checks++;
        if (step_out !== 1'b0) begin
            failures++;
            $display("FAIL reset_step_out: got %b want 0", step_out);
        end
        key = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        checks++;
        if (pos !== 5'd0) begin
            failures++;
            $display("FAIL reset_hold: got %0d want 0", pos);
        end
    endtask

    task automatic test_basic_paths();
        ring = 5'd0;
        f_in = 26'd1;
        b_in = 26'd1 << 4;
        #1;
        checks++;
        if (f_out !== (26'd1 << 4)) begin
            failures++;
            $display("FAIL a_to_e: got %h want %h", f_out, 26'd1 << 4);
        end
        checks++;
        if (b_out !== 26'd1) begin
            failures++;
            $display("FAIL e_back_a: got %h want %h", b_out, 26'd1);
        end
        f_in = 26'd0;
        b_in = 26'd0;
        #1;
        checks++;
        if (f_out !== 26'd0 || b_out !== 26'd0) begin
            failures++;
            $display("FAIL zero_in: got f=%h b=%h want 0", f_out, b_out);
        end
        f_in = 26'b11;
        #1;
        checks++;
        if (f_out !== ((26'd1 << 4) | (26'd1 << 10))) begin
            failures++;
            $display("FAIL multi_hot: got %h want %h", f_out, (26'd1 << 4) | (26'd1 << 10));
        end
        ring = 5'd27;
        f_in = 26'd1;
        #1;
        checks++;
        if (f_out !== (26'd1 << 4)) begin
            failures++;
            $display("FAIL ring_over: got %h want %h", f_out, 26'd1 << 4);
        end
        ring = 5'd0;
    endtask

    task automatic test_load_ring();
        load     = 1'b1;
        load_pos = 5'd1;
        f_in     = 26'd1;
        #1;
        checks++;
        if (f_out !== (26'd1 << 4) || pos !== 5'd0) begin
            failures++;
            $display("FAIL strobe_old_pos: got pos=%0d f=%h want pos=0 f=%h", pos, f_out, 26'd1 << 4);
        end
        tick();
        load = 1'b0;
        checks++;
        if (pos !== 5'd1 || f_out !== (26'd1 << 9)) begin
            failures++;
            $display("FAIL a_to_j: got pos=%0d f=%h want pos=1 f=%h", pos, f_out, 26'd1 << 9);
        end
        do_load(5'd0);
        ring = 5'd1;
        #1;
        checks++;
        if (f_out !== (26'd1 << 10)) begin
            failures++;
            $display("FAIL a_to_k_ring1: got %h want %h", f_out, 26'd1 << 10);
        end
        ring = 5'd0;
        f_in = 26'd0;
    endtask

    task automatic test_wrap_and_bad_load();
        do_load(5'd25);
        step_in = 1'b1;
        tick();
        step_in = 1'b0;
        checks++;
        if (pos !== 5'd0) begin
            failures++;
            $display("FAIL wrap_25_0: got %0d want 0", pos);
        end
        do_load(5'd12);
        do_load(5'd26);
        checks++;
        if (pos !== 5'd12) begin
            failures++;
            $display("FAIL load_26_ignored: got %0d want 12", pos);
        end
        step_in = 1'b1;
        tick();
        tick();
        step_in = 1'b0;
        checks++;
        if (pos !== 5'd14) begin
            failures++;
            $display("FAIL step_no_key: got %0d want 14", pos);
        end
    endtask

    task automatic test_notch();
        logic [4:0] exp_pos;
        do_load(5'd16);
        key     = 1'b0;
        step_in = 1'b1;
        #1;
        checks++;
        if (step_out !== 1'b0) begin
            failures++;
            $display("FAIL step_out_needs_key: got %b want 0", step_out);
        end
        step_in = 1'b0;
        key     = 1'b1;
        #1;
        checks++;
        if (step_out !== 1'b1) begin
            failures++;
            $display("FAIL notch_step_out: got %b want 1", step_out);
        end
        tick();
        key = 1'b0;
`ifdef ENIGMA_DOUBLE_STEP_EN
        exp_pos = 5'd17;
`else
        exp_pos = 5'd16;
`endif
        checks++;
        if (pos !== exp_pos) begin
            failures++;
            $display("FAIL notch_advance: got %0d want %0d", pos, exp_pos);
        end
        do_load(5'd15);
        key = 1'b1;
        #1;
        checks++;
        if (step_out !== 1'b0) begin
            failures++;
            $display("FAIL off_notch: got %b want 0", step_out);
        end
        key = 1'b0;
    endtask

    task automatic test_load_priority();
        do_load(5'd5);
        load     = 1'b1;
        load_pos = 5'd3;
        step_in  = 1'b1;
        tick();
        load    = 1'b0;
        step_in = 1'b0;
        checks++;
        if (pos !== 5'd3) begin
            failures++;
            $display("FAIL load_over_step: got %0d want 3", pos);
        end
        do_load(5'd16);
        load     = 1'b1;
        load_pos = 5'd2;
        key      = 1'b1;
        #1;
        checks++;
        if (step_out !== 1'b1) begin
            failures++;
            $display("FAIL load_key_step_out: got %b want 1", step_out);
        end
        tick();
        load = 1'b0;
        key  = 1'b0;
        checks++;
        if (pos !== 5'd2) begin
            failures++;
            $display("FAIL load_key_pos: got %0d want 2", pos);
        end
    endtask

    task automatic test_async_reset();
        do_load(5'd7);
        #1;
        reset_n = 1'b0;
        #1;
        checks++;
        if (pos !== 5'd0) begin
            failures++;
            $display("FAIL async_reset: got %0d want 0", pos);
        end
        reset_n = 1'b1;
        step_in = 1'b1;
        tick();
        step_in = 1'b0;
        checks++;
        if (pos !== 5'd1) begin
            failures++;
            $display("FAIL resume_after_reset: got %0d want 1", pos);
        end
    endtask

    task automatic test_sweep();
        int off;
        int o;
        logic [25:0] exp_f;
        logic [25:0] got_f;
        for (int p = 0; p < 26; p++) begin
            do_load(5'(p));
            for (int r = 0; r < 26; r++) begin
                ring = 5'(r);
                off  = (p - r + 26) % 26;
                for (int i = 0; i < 26; i++) begin
                    f_in = 26'd1 << i;
                    #1;
                    o     = (wmap[(i + off) % 26] - off + 26) % 26;
                    exp_f = 26'd1 << o;
                    got_f = f_out;
                    checks++;
                    if (got_f !== exp_f) begin
                        failures++;
                        $display("FAIL sweep_fwd p=%0d r=%0d i=%0d: got %h want %h", p, r, i, got_f, exp_f);
                    end
                    b_in = got_f;
                    #1;
                    checks++;
                    if (b_out !== f_in) begin
                        failures++;
                        $display("FAIL sweep_round p=%0d r=%0d i=%0d: got %h want %h", p, r, i, b_out, f_in);
                    end
                end
            end
        end
        f_in = 26'd0;
        b_in = 26'd0;
        ring = 5'd0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset_n  = 1'b0;
        key      = 1'b0;
        step_in  = 1'b0;
        load     = 1'b0;
        load_pos = 5'd0;
        ring     = 5'd0;
        f_in     = 26'd0;
        b_in     = 26'd0;
        build_model();
        test_reset();
        test_basic_paths();
        test_load_ring();
        test_wrap_and_bad_load();
        test_notch();
        test_load_priority();
        test_async_reset();
        test_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/enigma_rotor.md
ENIGMA_ROTOR -- requirements
Module: enigma_rotor

Interface
REQ-001 SHALL provide parameter WIRING, default "EKMFLGDQVZNTOWYHXUSPAIBRCJ", 26-char uppercase forward permutation, char k = output contact for input contact k.
REQ-002 SHALL provide parameter NOTCH, default "Q", single uppercase char: the turnover position.
REQ-003 SHALL provide parameter RESET_POS, default 0, position loaded at reset (0..25).
REQ-004 SHALL have ports, one per line, as follows:
  clk  input  1  single clock, rising edge
  reset_n  input  1  asynchronous, active-low reset
  key  input  1  one-cycle keystroke strobe
  step_in  input  1  advance request from the pawl on the right
  step_out  output  1  advance request to the rotor on the left
  load  input  1  position load strobe
  load_pos  input  5  position to load (0..25)
  ring  input  5  ring setting (0..25), quasi-static
  pos  output  5  current rotor position
  f_in / f_out  input / output  26  one-hot forward path, bit k = letter k
  b_in / b_out  input / output  26  one-hot backward path

Function
REQ-005 SHALL hold position in a 5-bit register exposed on pos, range 0..25 only.
REQ-006 SHALL compute offset = (pos - ring) mod 26; ring values above 25 SHALL be treated as 0.
REQ-007 Forward: f_in bit i SHALL drive f_out bit (W[(i+offset) mod 26] - offset) mod 26, where W is the WIRING permutation.
REQ-008 Backward: b_in bit j SHALL drive b_out bit (W⁻¹[(j+offset) mod 26] - offset) mod 26; forward then backward SHALL be the identity.
REQ-009 Both paths SHALL be combinational from inputs and the registered pos; zero latency; all-zero in SHALL give all-zero out; multi-hot inputs SHALL map bitwise.
REQ-010 step_out SHALL be combinational: key AND (pos == NOTCH-'A'); this is independent of step_in.
REQ-011 At the rising edge with load=1: pos SHALL take load_pos if load_pos ≤ 25, else keep its value; load SHALL override any step.
REQ-012 At the rising edge with load=0 and an advance condition: pos SHALL increment, 25 wrapping to 0.
REQ-013 Advance condition without the macro: step_in=1. step_in without key SHALL still advance the rotor, because the fast rotor ties step_in to key.
REQ-014 pos SHALL change only on the edge after the strobe; the paths SHALL use the old pos during the strobe cycle.
REQ-015 Simultaneous load and key SHALL still produce step_out from the pre-load pos.

Reset
REQ-016 reset_n low SHALL set pos to RESET_POS immediately, independent of clk; step_out SHALL then follow REQ-010 from the reset pos.
REQ-017 Deassertion mid-sequence SHALL resume stepping from RESET_POS on the first edge with reset_n high; no strobe is lost or replayed.

Configuration
REQ-018 Macro ENIGMA_DOUBLE_STEP_EN, when defined: advance condition SHALL be step_in OR (key AND pos == NOTCH-'A'). This is the middle-rotor double-step.
REQ-019 Macro ENIGMA_DOUBLE_STEP_EN, when undefined: advance condition SHALL be step_in only. Paths, load and reset are identical in both builds.

Verification (WIRING and NOTCH at defaults)
REQ-020 pos=0, ring=0, f_in=bit0 -> f_out=bit4 (A->E); b_in=bit4 -> b_out=bit0.
REQ-021 load_pos=1 then f_in=bit0 -> f_out=bit9 (A->J); load_pos=0, ring=1, f_in=bit0 -> f_out=bit10 (A->K).
REQ-022 pos=25, step_in=1 for one cycle -> pos=0 next cycle; load_pos=26 -> pos unchanged.
REQ-023 pos=16, key=1, step_in=0 -> step_out=1 same cycle; with macro pos=17 next cycle, without macro pos=16.
REQ-024 pos=5, load=1 with load_pos=3 and step_in=1 -> pos=3; reset_n low mid-cycle -> pos=RESET_POS before next edge.
REQ-025 Sweep all 26 pos x 26 rings x 26 one-hot inputs -> b_out(f_out(x)) equals x, and f_out equals a software Enigma model.
